iter_div: RTL and testbench

ITER_DIV -- requirements
Module: iter_div

---
 rtl/iter_div.sv | 131 +++++++++++++
 tb/tb_iter_div.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/iter_div.sv
// rtl/iter_div.sv - iterative 32/32 restoring divider, signed/unsigned, annul support
// Optional early termination for |dividend| < |divisor|: define DIV_EARLY_TERM_EN.
module iter_div (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

   state_t      state, state_n;
   logic [5:0]  cnt, cnt_n;
   logic [64:0] work, work_n;
   logic [31:0] div_b, div_b_n;
   logic        neg_q, neg_q_n;
   logic        neg_r, neg_r_n;
   logic [63:0] result_n;
   logic        ready_n;

   logic [31:0] mag_a, mag_b;
   logic [64:0] shifted;
   logic [33:0] diff;
   logic [31:0] q_fin, r_fin;

   assign mag_a = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
   assign mag_b = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;

   // Partial remainder lives in work[64:32], dividend/quotient bits in work[31:0].
   assign shifted = work << 1;
   assign diff    = {1'b0, shifted[64:32]} - {2'b00, div_b};
   assign q_fin   = neg_q ? -work[31:0]  : work[31:0];
   assign r_fin   = neg_r ? -work[63:32] : work[63:32];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= 6'd0;
         work     <= 65'd0;
         div_b    <= 32'd0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         result_o <= 64'd0;
         ready_o  <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         work     <= work_n;
         div_b    <= div_b_n;
         neg_q    <= neg_q_n;
         neg_r    <= neg_r_n;
         result_o <= result_n;
         ready_o  <= ready_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      work_n   = work;
      div_b_n  = div_b;
      neg_q_n  = neg_q;
      neg_r_n  = neg_r;
      result_n = result_o;
      ready_n  = ready_o;
      case (state)
         IDLE: begin
            if (start_i && !annul_i) begin
               cnt_n   = 6'd0;
               div_b_n = mag_b;
               neg_q_n = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
               neg_r_n = signed_div_i && opdata1_i[31];
               if (opdata2_i == 32'd0) begin
                  state_n = DIVZERO;
                  work_n  = 65'd0;
`ifdef DIV_EARLY_TERM_EN
               end else if (mag_a < mag_b) begin
                  // Preload the final answer (q=0, r=|a|); DIVZERO just finalises it.
                  state_n = DIVZERO;
                  work_n  = {1'b0, mag_a, 32'd0};
`endif
               end else begin
                  state_n = ON;
                  work_n  = {33'd0, mag_a};
               end
            end
         end
         DIVZERO: begin
            if (annul_i) begin
               state_n = IDLE;
               cnt_n   = 6'd0;
            end else if (cnt == 6'd1) begin
               state_n  = END;
               cnt_n    = 6'd0;
               result_n = {r_fin, q_fin};
               ready_n  = 1'b1;
            end else begin
               cnt_n = cnt + 6'd1;
            end
         end
         ON: begin
            if (annul_i) begin
               state_n = IDLE;
               cnt_n   = 6'd0;
            end else if (cnt == 6'd32) begin
               state_n  = END;
               cnt_n    = 6'd0;
               result_n = {r_fin, q_fin};
               ready_n  = 1'b1;
            end else begin
               work_n = diff[33] ? shifted : {diff[32:0], shifted[31:1], 1'b1};
               cnt_n  = cnt + 6'd1;
            end
         end
         END: begin
            if (!start_i) begin
               state_n  = IDLE;
               result_n = 64'd0;
               ready_n  = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_iter_div.sv
// tb/tb_iter_div.sv - scoreboard bench for iter_div
module tb_iter_div;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        signed_div_i = 1'b0;
   logic [31:0] opdata1_i = 32'd0;
   logic [31:0] opdata2_i = 32'd0;
   logic        start_i = 1'b0;
   logic        annul_i = 1'b0;
   logic [63:0] result_o;
   logic        ready_o;

   typedef struct {
      logic [63:0] res;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;

   iter_div dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      else
         passed++;
   endtask

   function automatic logic [63:0] model_res(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sbv, q, r;
      logic [31:0] q32, r32;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         sa  = longint'($signed(a));
         sbv = longint'($signed(b));
      end else begin
         sa  = longint'({32'd0, a});
         sbv = longint'({32'd0, b});
      end
      q   = sa / sbv;
      r   = sa % sbv;
      q32 = q[31:0];
      r32 = r[31:0];
      return {r32, q32};
   endfunction

   function automatic int model_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint ma, mb;
      if (b == 32'd0) return 2;
      ma = s ? longint'($signed(a)) : longint'({32'd0, a});
      mb = s ? longint'($signed(b)) : longint'({32'd0, b});
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
`ifdef DIV_EARLY_TERM_EN
      if (ma < mb) return 2;
`endif
      return 33;
   endfunction

   task automatic do_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   lat;
      e.res = model_res(s, a, b);
      e.lat = model_lat(s, a, b);
      sb.push_back(e);
      @(negedge clk);
      signed_div_i = s;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      @(posedge clk);
      #1;
      // Operands may wander after the start edge.
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = ~s;
      lat = 0;
      while (lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (ready_o) break;
      end
      e = sb.pop_front();
      check({tag, " ready"}, 64'(ready_o), 64'd1);
      check({tag, " latency"}, 64'(lat), 64'(e.lat));
      check({tag, " result"}, result_o, e.res);
      annul_i = 1'b1;
      @(posedge clk);
      #1;
      annul_i = 1'b0;
      check({tag, " hold"}, {result_o[62:0], ready_o}, {e.res[62:0], 1'b1});
      start_i = 1'b0;
      @(posedge clk);
      #1;
      check({tag, " release"}, {63'd0, ready_o} | result_o, 64'd0);
   endtask

   initial begin
      int seen;
      logic [31:0] ra, rb;
      #12;
      check("reset state", {63'd0, ready_o} | result_o, 64'd0);
      rst = 1'b0;

      do_div("u100/7", 1'b0, 32'd100, 32'd7);
      check("u100/7 const", model_res(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
      do_div("s-7/2", 1'b1, 32'hFFFFFFF9, 32'd2);
      do_div("s-min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF);
      do_div("div0", 1'b0, 32'h1234, 32'd0);
      do_div("s-5/0", 1'b1, 32'hFFFFFFFB, 32'd0);

      // Abort on the 10th ON cycle.
      @(negedge clk);
      signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
      @(posedge clk);
      repeat (9) @(posedge clk);
      #1;
      annul_i = 1'b1;
      start_i = 1'b0;
      @(posedge clk);
      #1;
      annul_i = 1'b0;
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (ready_o) seen++;
      end
      check("annul no ready", 64'(seen), 64'd0);
      do_div("9/3 after annul", 1'b0, 32'd9, 32'd3);

      // Reset between edges, mid-ON.
      @(negedge clk);
      signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
      @(posedge clk);
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("rst mid-ON", {63'd0, ready_o} | result_o, 64'd0);
      start_i = 1'b0;
      #2;
      rst = 1'b0;
      do_div("50/5 after rst", 1'b0, 32'd50, 32'd5);

      // Reset while parked in END clears outputs asynchronously.
      @(negedge clk);
      signed_div_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd4; start_i = 1'b1;
      seen = 0;
      while (seen < 40 && !ready_o) begin
         @(posedge clk);
         #1;
         seen++;
      end
      check("END ready", 64'(ready_o), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check("rst in END", {63'd0, ready_o} | result_o, 64'd0);
      start_i = 1'b0;
      #1;
      rst = 1'b0;

      do_div("u5/9", 1'b0, 32'd5, 32'd9);
      do_div("s-5/9", 1'b1, 32'hFFFFFFFB, 32'd9);
      do_div("uffff/1", 1'b0, 32'hFFFFFFFF, 32'd1);
      do_div("uffff/ffff", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      do_div("s7/-2", 1'b1, 32'd7, 32'hFFFFFFFE);
      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = (i < 4) ? ($urandom >> (i * 7)) : $urandom_range(1, 1000);
         do_div($sformatf("rand%0d", i), i[0], ra, rb);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
